gray_updown_counter: RTL and testbench

//  Parametrised up/down counter whose state register is held in Gray code; binary view also registered.

---
 rtl/gray_pkg.sv | 32 +++
 rtl/gray_decode.sv | 21 ++
 rtl/gray_updown_counter.sv | 141 ++++++++++++++
 tb/tb_gray_updown_counter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and Gray-code helpers for the Gray up/down counter.
// Helpers work on a fixed 32-bit container; zero-extended narrower values convert correctly.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } op_e;

    function automatic logic [GRAY_MAX_W-1:0] bin_to_gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Leading zeros of a zero-extended code leave the prefix XOR unchanged.
    function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic multi_bit_change(input logic [GRAY_MAX_W-1:0] d);
        return (d & (d - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/gray_decode.sv
// Combinational Gray-to-binary decoder, WIDTH bits.
module gray_decode
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    logic [GRAY_MAX_W-1:0] bin_wide_s;
    logic                  unused_s;

    // Decode through the shared helper and keep the low WIDTH bits.
    always_comb begin
        bin_wide_s = gray_to_bin(GRAY_MAX_W'(gray));
        bin        = bin_wide_s[WIDTH-1:0];
        unused_s   = ^bin_wide_s;
    end

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down counter holding its state in Gray code, with load and wrap/saturate modes.
// Optional Gray-integrity checker enabled by defining GRAY_CHECK_EN.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray_q,
    output logic [WIDTH-1:0] bin_q,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      gray_r;
    logic [WIDTH-1:0]      bin_r;
    logic                  wrap_r;
    logic [WIDTH-1:0]      cur_bin_s;
    logic [WIDTH-1:0]      next_bin_s;
    logic [WIDTH-1:0]      next_gray_s;
    logic                  wrap_next_s;
    logic [GRAY_MAX_W-1:0] gray_wide_s;
    logic                  unused_s;
    op_e                   op_s;

    // Arithmetic always starts from the decoded Gray state, the single source of truth.
    gray_decode #(.WIDTH(WIDTH)) u_decode (
        .gray (gray_r),
        .bin  (cur_bin_s)
    );

    // Resolve the per-edge operation: load beats count enable beats hold.
    always_comb begin
        op_s = OP_HOLD;
        if (load) begin
            op_s = OP_LOAD;
        end else if (en) begin
            op_s = up ? OP_UP : OP_DOWN;
        end else begin
            op_s = OP_HOLD;
        end
    end

    // Next binary value and wrap/limit flag for the selected operation.
    always_comb begin
        next_bin_s  = cur_bin_s;
        wrap_next_s = 1'b0;
        case (op_s)
            OP_LOAD: begin
                next_bin_s = load_val;
            end
            OP_UP: begin
                if (cur_bin_s == MAX) begin
                    wrap_next_s = 1'b1;
                    next_bin_s  = WRAP ? ZERO : MAX;
                end else begin
                    next_bin_s = cur_bin_s + ONE;
                end
            end
            OP_DOWN: begin
                if (cur_bin_s == ZERO) begin
                    wrap_next_s = 1'b1;
                    next_bin_s  = WRAP ? MAX : ZERO;
                end else begin
                    next_bin_s = cur_bin_s - ONE;
                end
            end
            default: begin
                next_bin_s = cur_bin_s;
            end
        endcase
    end

    // Gray encoding of the next value, derived from the same binary so both views agree.
    always_comb begin
        gray_wide_s = bin_to_gray(GRAY_MAX_W'(next_bin_s));
        next_gray_s = gray_wide_s[WIDTH-1:0];
        unused_s    = ^gray_wide_s;
    end

    // Counter state and wrap pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_r <= ZERO;
            bin_r  <= ZERO;
            wrap_r <= 1'b0;
        end else begin
            gray_r <= next_gray_s;
            bin_r  <= next_bin_s;
            wrap_r <= wrap_next_s;
        end
    end

    assign gray_q = gray_r;
    assign bin_q  = bin_r;
    assign wrap   = wrap_r;

`ifdef GRAY_CHECK_EN
    logic [WIDTH-1:0]      prev_gray_r;
    logic                  armed_r;
    logic                  err_r;
    logic [GRAY_MAX_W-1:0] diff_s;

    // armed_r is set only when the held gray_r came from a non-load edge after reset.
    always_comb begin
        diff_s = GRAY_MAX_W'(gray_r ^ prev_gray_r);
    end

    // Sticky integrity flag: more than one bit moved between consecutive registered values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray_r <= ZERO;
            armed_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            prev_gray_r <= gray_r;
            armed_r     <= ~load;
            if (armed_r && multi_bit_change(diff_s)) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_updown_counter.sv
// Randomised self-checking bench: a wrapping and a saturating counter against an integer model.
module tb_gray_updown_counter;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] g_w, b_w, g_s, b_s;
    logic         w_w, e_w, w_s, e_s;

    int total = 0;
    int bad   = 0;
    int mv_w, mv_s;
    bit ew_w, ew_s;

    gray_updown_counter #(.WIDTH(W), .WRAP(1'b1)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .gray_q(g_w), .bin_q(b_w), .wrap(w_w), .err(e_w)
    );

    gray_updown_counter #(.WIDTH(W), .WRAP(1'b0)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val),
        .gray_q(g_s), .bin_q(b_s), .wrap(w_s), .err(e_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference rules: counting in plain integers, limits handled per mode.
    function automatic int model_next(input int v, input bit ld, input int lv, input bit e,
                                      input bit u, input bit wrapm, output bit w);
        w = 1'b0;
        if (ld) return lv;
        if (!e) return v;
        if (u) begin
            if (v == MAXV) begin
                w = 1'b1;
                return wrapm ? 0 : MAXV;
            end
            return v + 1;
        end
        if (v == 0) begin
            w = 1'b1;
            return wrapm ? MAXV : 0;
        end
        return v - 1;
    endfunction

    function automatic int to_gray(input int v);
        return v ^ (v >> 1);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".w.bin"},  b_w, mv_w);
        chk({tag, ".w.gray"}, g_w, to_gray(mv_w));
        chk({tag, ".w.wrap"}, w_w, ew_w);
        chk({tag, ".w.err"},  e_w, 0);
        chk({tag, ".s.bin"},  b_s, mv_s);
        chk({tag, ".s.gray"}, g_s, to_gray(mv_s));
        chk({tag, ".s.wrap"}, w_s, ew_s);
        chk({tag, ".s.err"},  e_s, 0);
    endtask

    task automatic step(input string tag, input bit ld, input int lv, input bit e, input bit u);
        logic [W-1:0] prev_g;
        int           prev_m;
        load = ld; load_val = W'(lv); en = e; up = u;
        prev_g = g_w;
        prev_m = mv_w;
        mv_w = model_next(mv_w, ld, lv, e, u, 1'b1, ew_w);
        mv_s = model_next(mv_s, ld, lv, e, u, 1'b0, ew_s);
        @(posedge clk);
        #1;
        check_all(tag);
        if (!ld) chk({tag, ".flips"}, $countones(prev_g ^ g_w), (prev_m != mv_w) ? 1 : 0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = '0;
        mv_w = 0; mv_s = 0; ew_w = 1'b0; ew_s = 1'b0;
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Count to 9, then assert reset mid-cycle: outputs must clear without a clock edge.
        for (int i = 0; i < 9; i++) step("pre", 1'b0, 0, 1'b1, 1'b1);
        chk("mid.bin9", b_w, 9);
        #3;
        rst_n = 1'b0;
        #1;
        mv_w = 0; mv_s = 0; ew_w = 1'b0; ew_s = 1'b0;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step("rel", 1'b0, 0, 1'b0, 1'b1);

        // Full up cycle from 0 through the wrap.
        for (int i = 0; i < 16; i++) step("up16", 1'b0, 0, 1'b1, 1'b1);
        chk("up16.end", b_w, 0);

        // Load takes priority over an enabled count.
        step("load6", 1'b1, 6, 1'b1, 1'b1);
        chk("load6.gray", g_w, 4'b0101);

        // Down from 0: wrap to 15 vs saturate at 0.
        step("ld0", 1'b1, 0, 1'b0, 1'b0);
        step("dn0", 1'b0, 0, 1'b1, 1'b0);
        chk("dn0.gray", g_w, 4'b1000);
        step("dn0.after", 1'b0, 0, 1'b0, 1'b0);

        // Up at 15 for three edges.
        step("ld15", 1'b1, 15, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step("sat_up", 1'b0, 0, 1'b1, 1'b1);
        chk("sat_up.hold", b_s, 15);

        // Random mix, including direction reversals and mid-stream loads.
        for (int i = 0; i < 400; i++) begin
            step("rnd", $urandom_range(0, 9) == 0, $urandom_range(0, MAXV),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end

`ifdef GRAY_CHECK_EN
        step("ck.ld1", 1'b1, 1, 1'b0, 1'b0);
        step("ck.hold", 1'b0, 0, 1'b0, 1'b0);
        force u_dut_wrap.gray_r = 4'b0111;
        @(posedge clk);
        #1;
        release u_dut_wrap.gray_r;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("ck.err_sticky", e_w, 1);
        end
        chk("ck.other_clean", e_s, 0);
        rst_n = 1'b0;
        #1;
        chk("ck.err_clear", e_w, 0);
        mv_w = 0; mv_s = 0; ew_w = 1'b0; ew_s = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("ck.after", 1'b0, 0, 1'b1, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
